// File: rtl/teamd_rx_frame_ctrl.sv
// Serial receive frame controller: synchronises Rx, sequences start/data/[parity]/stop, parity present with TEAMD_RX_PARITY_EN.
// Latency: Busy 3 cycles after the start edge; Valid one cycle after the stop sample.
// Backpressure: a frame completing while Valid is held without Ack is dropped and sets Overrun.
module teamd_rx_frame_ctrl #(
   parameter int BIT_CLKS = 16,
   parameter int CNT_W    = 5
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       Rx,
   input  logic       Ack,
   output logic [6:0] Data,
   output logic       Valid,
   output logic       ParityErr,
   output logic       FrameErr,
   output logic       Overrun,
   output logic       ShiftEn,
   output logic       Busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CLKS/2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CLKS - 1);

   state_t           state;
   logic             rx_meta;
   logic             rxs;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [6:0]       shreg;
   logic             bit_smp;
   logic             stop_smp;
`ifdef TEAMD_RX_PARITY_EN
   logic             par_bad;
   logic             par_err_q;
   assign ParityErr = par_err_q;
`else
   assign ParityErr = 1'b0;
`endif

   assign bit_smp  = (cnt == FULL_M1);
   assign stop_smp = (state == STOP) && bit_smp;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         rx_meta  <= 1'b1;
         rxs      <= 1'b1;
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         Data     <= '0;
         Valid    <= 1'b0;
         FrameErr <= 1'b0;
         Overrun  <= 1'b0;
         ShiftEn  <= 1'b0;
         Busy     <= 1'b0;
`ifdef TEAMD_RX_PARITY_EN
         par_bad   <= 1'b0;
         par_err_q <= 1'b0;
`endif
      end else begin
         rx_meta <= Rx;
         rxs     <= rx_meta;
         ShiftEn <= 1'b0;

         case (state)
            IDLE: begin
               if (!rxs) begin
                  state   <= START;
                  cnt     <= '0;
                  bit_idx <= '0;
                  Busy    <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  if (!rxs) begin
                     state <= DATA;
                  end else begin
                     state <= IDLE;
                     Busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_smp) begin
                  cnt     <= '0;
                  shreg   <= {rxs, shreg[6:1]};
                  ShiftEn <= 1'b1;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd6) begin
`ifdef TEAMD_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef TEAMD_RX_PARITY_EN
            PARITY: begin
               if (bit_smp) begin
                  cnt     <= '0;
                  ShiftEn <= 1'b1;
                  // even parity: data plus parity bit must hold an even count of ones
                  par_bad <= ^{shreg, rxs};
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_smp) begin
                  cnt <= '0;
                  if (rxs) begin
                     state <= IDLE;
                     Busy  <= 1'b0;
                  end else begin
                     state <= BREAK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BREAK: begin
               if (rxs) begin
                  state <= IDLE;
                  Busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
         endcase

         // a completion in the same cycle as Ack hands the new frame straight over
         if (stop_smp) begin
            if (!Valid || Ack) begin
               Data     <= shreg;
               Valid    <= 1'b1;
               FrameErr <= ~rxs;
               Overrun  <= 1'b0;
`ifdef TEAMD_RX_PARITY_EN
               par_err_q <= par_bad;
`endif
            end else begin
               Overrun <= 1'b1;
            end
         end else if (Ack && Valid) begin
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
`ifdef TEAMD_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_teamd_rx_frame_ctrl.sv
// Bench for teamd_rx_frame_ctrl: directed frames plus random frames against a transaction-level model.
module tb_teamd_rx_frame_ctrl;
`ifdef TEAMD_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int B     = 4;
   localparam int NBITS = 9 + PAR;                  // start, 7 data, [parity], stop
   localparam int LAT_V = 3 + B/2 + (NBITS-1)*B;    // pin start edge to Valid visible
   localparam int NSH   = 7 + PAR;

   logic       CLK = 1'b0;
   logic       Reset;
   logic       Rx;
   logic       Ack;
   logic [6:0] Data;
   logic       Valid, ParityErr, FrameErr, Overrun, ShiftEn, Busy;

   int   cyc, busy_rise, valid_rise, shift_tot;
   logic busy_q = 1'b0;
   logic valid_q = 1'b0;
   int   compared, mismatched;
   int   c0;
   int   m_data, m_valid, m_pe, m_fe, m_ov;

   teamd_rx_frame_ctrl #(.BIT_CLKS(B), .CNT_W(3)) dut (
      .CLK(CLK), .Reset(Reset), .Rx(Rx), .Ack(Ack), .Data(Data), .Valid(Valid),
      .ParityErr(ParityErr), .FrameErr(FrameErr), .Overrun(Overrun),
      .ShiftEn(ShiftEn), .Busy(Busy)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      busy_q  <= Busy;
      valid_q <= Valid;
      if (Busy && !busy_q) busy_rise <= cyc;
      if (Valid && !valid_q) valid_rise <= cyc;
      if (ShiftEn === 1'b1) shift_tot <= shift_tot + 1;
   end

   initial begin
      repeat (40000) @(posedge CLK);
      $display("FAIL watchdog: cycle budget expired before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send_frame(input int d, input int pb, input int sb, input int idle);
      logic [10:0] seq;
      seq = '0;
      for (int i = 0; i < 7; i++) seq[i+1] = d[i];
      if (PAR != 0) begin
         seq[8] = pb[0];
         seq[9] = sb[0];
      end else begin
         seq[8] = sb[0];
      end
      c0 = cyc;
      for (int b = 0; b < NBITS; b++) begin
         Rx = seq[b];
         step(B);
      end
      Rx = idle[0];
   endtask

   task automatic model_complete(input int d, input int pb, input int sb, input int ack_now);
      if (m_valid == 0 || ack_now != 0) begin
         m_data  = d;
         m_pe    = (PAR != 0) ? (($countones(d) + pb) % 2) : 0;
         m_fe    = (sb == 0) ? 1 : 0;
         m_ov    = 0;
         m_valid = 1;
      end else begin
         m_ov = 1;
      end
   endtask

   task automatic model_ack();
      if (m_valid != 0) begin
         m_valid = 0;
         m_pe    = 0;
         m_fe    = 0;
         m_ov    = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".data"},  32'(Data),      m_data);
      chk({tag, ".valid"}, 32'(Valid),     m_valid);
      chk({tag, ".perr"},  32'(ParityErr), m_pe);
      chk({tag, ".ferr"},  32'(FrameErr),  m_fe);
      chk({tag, ".ovr"},   32'(Overrun),   m_ov);
   endtask

   task automatic frame_checks(input string tag, input int sh_base, input int nframes, input int was_valid);
      chk({tag, ".shift"}, shift_tot - sh_base, nframes * NSH);
      chk({tag, ".brise"}, busy_rise, c0 + 3);
      if (was_valid == 0) chk({tag, ".vrise"}, valid_rise, c0 + LAT_V);
      check_all(tag);
   endtask

   task automatic pulse_ack();
      Ack = 1'b1;
      step(1);
      Ack = 1'b0;
      model_ack();
   endtask

   initial begin
      int d, pb, sb, gap, sh, s, wasv, flip;
      Reset = 1'b1; Rx = 1'b1; Ack = 1'b0;
      step(3);
      chk("rst.data", 32'(Data), 0);
      chk("rst.valid", 32'(Valid), 0);
      chk("rst.perr", 32'(ParityErr), 0);
      chk("rst.ferr", 32'(FrameErr), 0);
      chk("rst.ovr", 32'(Overrun), 0);
      chk("rst.shift", 32'(ShiftEn), 0);
      chk("rst.busy", 32'(Busy), 0);
      Reset = 1'b0;
      step(3);

      // clean 0x55, then Ack, then a stray Ack while Valid is low
      sh = shift_tot;
      send_frame('h55, 0, 1, 1); step(4);
      model_complete('h55, 0, 1, 0);
      frame_checks("f55", sh, 1, 0);
      chk("f55.busy_idle", 32'(Busy), 0);
      pulse_ack();
      check_all("f55_ack");
      pulse_ack();
      check_all("stray_ack");

      // 0x01 with parity bit 0 (wrong when parity is enabled)
      sh = shift_tot;
      send_frame('h01, 0, 1, 1); step(4);
      model_complete('h01, 0, 1, 0);
      frame_checks("f01", sh, 1, 0);
      chk("f01.perr_const", 32'(ParityErr), PAR);
      pulse_ack();

      // 0x7F with stop low: line held low keeps the receiver busy
      sh = shift_tot;
      send_frame('h7F, 1, 0, 0); step(8);
      model_complete('h7F, 1, 0, 0);
      frame_checks("f7f", sh, 1, 0);
      chk("brk.busy", 32'(Busy), 1);
      Rx = 1'b1; step(4);
      chk("brk.released", 32'(Busy), 0);
      pulse_ack();
      check_all("f7f_ack");

      // one-cycle low glitch on the line
      sh = shift_tot; s = cyc;
      Rx = 1'b0; step(B/4); Rx = 1'b1; step(12);
      chk("glitch.brise", busy_rise, s + 3);
      chk("glitch.busy", 32'(Busy), 0);
      chk("glitch.shift", shift_tot - sh, 0);
      chk("glitch.valid", 32'(Valid), 0);

      // two back-to-back frames, no Ack: second one is lost
      sh = shift_tot;
      send_frame('h12, 0, 1, 1);
      send_frame('h34, 1, 1, 1); step(4);
      model_complete('h12, 0, 1, 0);
      model_complete('h34, 1, 1, 0);
      frame_checks("b2b", sh, 2, 1);
      pulse_ack();
      check_all("b2b_ack");

      // repeat with Ack during the completion cycle of frame 2
      sh = shift_tot;
      send_frame('h12, 0, 1, 1);
      s = c0 + NBITS*B + LAT_V - 1;
      fork
         send_frame('h34, 1, 1, 1);
         begin
            while (cyc < s) step(1);
            Ack = 1'b1; step(1); Ack = 1'b0;
         end
      join
      step(4);
      model_complete('h12, 0, 1, 0);
      model_complete('h34, 1, 1, 1);
      frame_checks("b2b_ackc", sh, 2, 1);

      // Reset after the third data bit, with a frame still held
      d = 'h2A;
      Rx = 1'b0; step(B);
      for (int k = 0; k < 3; k++) begin
         Rx = d[k];
         step(B);
      end
      Rx = d[3]; step(3);
      chk("midrst.busy_before", 32'(Busy), 1);
      Reset = 1'b1; Rx = 1'b1; step(1);
      m_data = 0; m_valid = 0; m_pe = 0; m_fe = 0; m_ov = 0;
      check_all("midrst");
      chk("midrst.busy", 32'(Busy), 0);
      chk("midrst.shift", 32'(ShiftEn), 0);
      Reset = 1'b0; step(4);
      sh = shift_tot;
      send_frame('h2A, 1, 1, 1); step(4);
      model_complete('h2A, 1, 1, 0);
      frame_checks("f2a", sh, 1, 0);
      chk("f2a.data_const", 32'(Data), 'h2A);
      pulse_ack();

      // random frames, random Ack decisions
      for (int i = 0; i < 12; i++) begin
         d    = int'($urandom_range(0, 127));
         flip = ($urandom_range(0, 3) == 0) ? 1 : 0;
         pb   = ($countones(d) % 2) ^ flip;
         sb   = ($urandom_range(0, 3) != 0) ? 1 : 0;
         gap  = int'($urandom_range(0, 6));
         wasv = m_valid;
         sh   = shift_tot;
         send_frame(d, pb, sb, sb);
         if (sb == 0) begin
            step(gap + 1);
            Rx = 1'b1;
         end
         step(4);
         model_complete(d, pb, sb, 0);
         frame_checks($sformatf("rnd%0d", i), sh, 1, wasv);
         if ($urandom_range(0, 1) == 1) begin
            pulse_ack();
            check_all($sformatf("rnd%0d_ack", i));
         end
         step(gap);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/teamd_rx_frame_ctrl.md
# teamd_rx_frame_ctrl

Frame controller for the team's serial receive path. Samples the asynchronous `Rx` line at a configurable bit period and sequences the 8-bit receive shift chain (7 data bits D6..D0 plus parity P) through start detection, data capture, parity check and stop check. Delivers each completed character on a parallel port with a valid/acknowledge handshake. Sits between the top-level `Rx` pad input and the consumer of received characters; it replaces a free-running load strobe with a bit-timed one.

## Interface
- `BIT_CLKS`, 16: `CLK` cycles per bit; even, ≥4.
- `CNT_W`, 5: bit-period counter width; must satisfy 2^CNT_W > BIT_CLKS.
- `CLK` input 1: sole clock, rising edge.
- `Reset` input 1: synchronous, active-high.
- `Rx` input 1: serial line, asynchronous, idle high.
- `Ack` input 1: consumer has taken `Data`.
- `Data` output 7: received character, LSB = first data bit received.
- `Valid` output 1: `Data`/status flags hold a completed frame.
- `ParityErr` output 1: parity mismatch on the held frame.
- `FrameErr` output 1: stop bit sampled low on the held frame.
- `Overrun` output 1: one or more frames lost while `Valid` was high.
- `ShiftEn` output 1: one-cycle pulse on each data/parity sample.
- `Busy` output 1: state ≠ IDLE.

## Operation
- `Rx` passes through a 2-flop synchroniser; all logic uses the synchronised `rxs`.
- Frame: start (0), 7 data bits LSB first, even-parity bit (data+parity ones count even), stop (1).
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: `rxs`=0 → START, counter cleared.
- START: after BIT_CLKS/2 cycles sample `rxs`; 0 → DATA, counter cleared; 1 → IDLE (glitch rejected, no flags).
- DATA: sample every BIT_CLKS cycles; shift sample into bit 6 of the internal shift register, right-shift toward bit 0; `ShiftEn` pulses on each sample; after the 7th sample → PARITY.
- PARITY: one sample; store parity result; → STOP.
- STOP: one sample. Complete frame; if `rxs`=1 → IDLE, else → BREAK.
- BREAK: wait for `rxs`=1, then → IDLE.
- Completion with `Valid`=0, or with `Valid`=1 and `Ack`=1 in the same cycle: load `Data`, `ParityErr`, `FrameErr`; `Valid`=1.
- Completion with `Valid`=1 and `Ack`=0: frame discarded, `Data`/flags unchanged, `Overrun` set.
- `Ack` with `Valid`=1 and no completion: `Valid`, `ParityErr`, `FrameErr`, `Overrun` cleared next cycle. `Ack` with `Valid`=0 is ignored.
- `Data` stable for the whole time `Valid`=1.

## Timing
- Reset: state IDLE, counter 0, synchroniser flops 1; `Data`=0, `Valid`=0, `ParityErr`=0, `FrameErr`=0, `Overrun`=0, `ShiftEn`=0, `Busy`=0.
- `Reset` mid-frame aborts the frame; no flags raised; held `Valid` frame dropped.
- Start edge on pin → `Busy`=1 after 3 cycles (2 sync + 1 state register).
- Data bit k (0..6) sampled BIT_CLKS/2 + (k+1)·BIT_CLKS cycles after START entry; parity at +8·BIT_CLKS, stop at +9·BIT_CLKS.
- `Valid` rises the cycle after the stop sample; earliest next IDLE→START also that cycle.
- Registered outputs only; no combinational path from `Rx` or `Ack` to any output.

## Configuration
- `TEAMD_RX_PARITY_EN` defined: frame and behaviour as above.
- Undefined: PARITY state removed, DATA → STOP directly; stop sample at +8·BIT_CLKS; `ParityErr` tied 0; frame is 9 bits.

## Test plan
- BIT_CLKS=4, parity on: send 0x55 (parity 0, stop 1) → `Data`=0x55, `Valid`=1, `ParityErr`=0, `FrameErr`=0, 7 `ShiftEn` pulses + 1 parity pulse; `Ack` → `Valid`=0 next cycle.
- Send 0x01 with parity bit 0 → `Data`=0x01, `ParityErr`=1; second frame 0x7F with stop bit 0 → `FrameErr`=1, state BREAK until `Rx`=1.
- `Rx` low for 1 bit-period/4 only → START then IDLE, `Valid` stays 0, no `ShiftEn`.
- Two frames 0x12, 0x34 back-to-back, no `Ack` → `Data`=0x12, `Overrun`=1; repeat with `Ack` in stop-completion cycle of frame 2 → `Data`=0x34, `Valid`=1, `Overrun`=0.
- Assert `Reset` after 3rd data bit → all outputs reset values next cycle; following clean frame 0x2A received correctly.
- Parity macro undefined: send 0x2A with stop at 9th bit → `Valid`=1, `Data`=0x2A, `ParityErr`=0.
